// File: rtl/dmem_pkg.sv
// Shared types and constants for the variable-latency data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int MAX_LATENCY = 7;
    localparam int CNT_W       = 3;

    // Counter preload: the accept cycle already counts as one stall cycle.
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read by word index.
module dmem_array #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle stores, loads that stall the core
// for a fixed programmable latency before returning registered data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misaligned
);

    localparam int AW  = DEPTH_LOG2;
    localparam int LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                         (LATENCY < 1) ? 1 : LATENCY;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_idx;
    logic [31:0]      r_rdata;
    logic             r_mis;

    logic          w_idle;
    logic          w_we;
    logic          w_bad;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_word;
    logic [31:0]   w_fwd;
    logic          w_unused;

    assign w_idle   = (r_state == IDLE);
    assign w_idx    = adr[AW+1:2];
    assign w_we     = w_idle & memwrite & ~reset;
    assign w_bad    = w_idle & (memread | memwrite) & (adr[1:0] != 2'b00);
    assign w_raddr  = w_idle ? w_idx : r_idx;
    // A same-cycle store must be visible to a LATENCY=1 load at the accept edge.
    assign w_fwd    = w_we ? writedata : w_word;
    assign w_unused = ^adr[31:AW+2];

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (writedata),
        .i_raddr (w_raddr),
        .o_rdata (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            if (w_bad) begin
                r_mis <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (memread) begin
                        r_idx <= w_idx;
                        if (LAT == 1) begin
                            r_rdata <= w_fwd;
                            r_cnt   <= '0;
                            r_state <= RESP;
                        end else begin
                            r_cnt   <= lat_preload(LAT);
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= w_word;
                        r_cnt   <= '0;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall      = (w_idle & memread) | (r_state == WAIT);
    assign readdata   = r_rdata;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four builds (LATENCY 2,1,7,4) against a behavioural model.
module tb_dmem_responder;

    logic        clk;
    logic        rst [4];
    logic        mr  [4];
    logic        mw  [4];
    logic [31:0] ad  [4];
    logic [31:0] wd  [4];
    logic [31:0] rd  [4];
    logic        st  [4];
    logic        mis [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2(6),
            .LATENCY(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 7 : 4)
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .memread    (mr[g]),
            .memwrite   (mw[g]),
            .adr        (ad[g]),
            .writedata  (wd[g]),
            .readdata   (rd[g]),
            .stall      (st[g]),
            .misaligned (mis[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 7;
            default: return 4;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    // Behavioural model state
    logic [31:0] m    [4][64];
    logic        busy [4];
    int          done [4];
    logic [31:0] pend [4];
    logic [31:0] erd  [4];
    logic        emis [4];
    logic        armed[4];
    int          run  [4];
    logic        ab   [4];
    logic        len  [4];
    logic [31:0] lv   [4];
    int          cyc;
    int          nvec;
    int          nerr;

    initial begin
        cyc  = 0;
        nvec = 0;
        nerr = 0;
        for (int i = 0; i < 4; i++) begin
            busy[i]  = 1'b0;
            done[i]  = 0;
            pend[i]  = '0;
            erd[i]   = '0;
            emis[i]  = 1'b0;
            armed[i] = 1'b0;
            run[i]   = 0;
            ab[i]    = 1'b0;
        end
    end

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] cyc %0d: got %h want %h",
                     nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic estall;
            if (busy[i] && cyc == done[i]) erd[i] = pend[i];
            estall = (!busy[i] && mr[i]) || (busy[i] && cyc < done[i]);
            if (armed[i]) begin
                chk("stall", i, 32'(st[i]), 32'(estall));
                chk("readdata", i, rd[i], erd[i]);
                chk("misaligned", i, 32'(mis[i]), 32'(emis[i]));
            end
            // Literal pins: measured stall width and returned word.
            if (st[i] === 1'b1) begin
                run[i]++;
                if (rst[i]) ab[i] = 1'b1;
            end else if (run[i] > 0) begin
                if (!ab[i]) begin
                    chk("width", i, 32'(run[i]), 32'(lat_of(i)));
                    if (len[i]) chk("pin", i, rd[i], lv[i]);
                end
                run[i] = 0;
                ab[i]  = 1'b0;
            end
            if (busy[i] && cyc == done[i]) begin
                busy[i] = 1'b0;
            end else if (!busy[i]) begin
                if (mw[i]) begin
                    m[i][idx_of(ad[i])] = wd[i];
                    if (ad[i][1:0] != 2'b00) emis[i] = 1'b1;
                end
                if (mr[i]) begin
                    pend[i] = m[i][idx_of(ad[i])];
                    done[i] = cyc + lat_of(i);
                    busy[i] = 1'b1;
                    if (ad[i][1:0] != 2'b00) emis[i] = 1'b1;
                end
            end
            if (rst[i]) begin
                busy[i]  = 1'b0;
                erd[i]   = '0;
                emis[i]  = 1'b0;
                armed[i] = 1'b1;
            end
        end
        cyc++;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d);
        mw[i] = 1'b1;
        ad[i] = a;
        wd[i] = d;
        go();
        mw[i] = 1'b0;
    endtask

    task automatic rd_op(input int i, input logic [31:0] a, input logic [31:0] pin);
        int n;
        len[i] = 1'b1;
        lv[i]  = pin;
        mr[i]  = 1'b1;
        ad[i]  = a;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (st[i] && n < 12);
        mr[i] = 1'b0;
        go();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            mr[i]  = 1'b0;
            mw[i]  = 1'b0;
            ad[i]  = '0;
            wd[i]  = '0;
            len[i] = 1'b0;
            lv[i]  = '0;
        end
        go();
        go();
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        go();

        // Store then load, back-to-back stores and loads
        wr(0, 32'h10, 32'hDEADBEEF);
        rd_op(0, 32'h10, 32'hDEADBEEF);
        wr(0, 32'h40, 32'h1);
        wr(0, 32'h44, 32'h2);
        wr(0, 32'h48, 32'h3);
        rd_op(0, 32'h44, 32'h2);
        rd_op(0, 32'h48, 32'h3);

        // Simultaneous read+write, then ignored write and address change in WAIT
        len[0] = 1'b1;
        lv[0]  = 32'hA5A5A5A5;
        mr[0]  = 1'b1;
        mw[0]  = 1'b1;
        ad[0]  = 32'h20;
        wd[0]  = 32'hA5A5A5A5;
        go();
        wd[0]  = 32'h0;
        ad[0]  = 32'h10;
        go();
        mw[0]  = 1'b0;
        mr[0]  = 1'b0;
        go();
        rd_op(0, 32'h20, 32'hA5A5A5A5);

        // Misaligned store wraps to word 0; flag stays set
        wr(0, 32'h102, 32'h11);
        rd_op(0, 32'h002, 32'h11);
        go();

        // LATENCY=1 and LATENCY=7 builds
        wr(1, 32'h04, 32'h12345678);
        rd_op(1, 32'h04, 32'h12345678);
        wr(1, 32'h08, 32'hCAFEF00D);
        len[1] = 1'b1;
        lv[1]  = 32'h0BADC0DE;
        mr[1]  = 1'b1;
        mw[1]  = 1'b1;
        ad[1]  = 32'h08;
        wd[1]  = 32'h0BADC0DE;
        go();
        mr[1]  = 1'b0;
        mw[1]  = 1'b0;
        go();
        wr(2, 32'h04, 32'h12345678);
        rd_op(2, 32'h04, 32'h12345678);

        // Reset during the second stall cycle of a LATENCY=4 load
        wr(3, 32'h1, 32'h77);
        len[3] = 1'b0;
        mr[3]  = 1'b1;
        ad[3]  = 32'h0;
        go();
        rst[3] = 1'b1;
        mr[3]  = 1'b0;
        go();
        rst[3] = 1'b0;
        go();
        rd_op(3, 32'h0, 32'h77);

        go();
        go();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
